// File: rtl/bus_arb_pkg.sv
// Shared types for the bus_arb DMA/core memory arbiter.
// Round-robin channel priority is selected at build time with ARB_RR_EN.
package bus_arb_pkg;

  localparam int NUM_CH = 2;

  typedef enum logic [1:0] {
    ST_CPU = 2'd0,
    ST_GNT = 2'd1,
    ST_REL = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MUX_CPU = 2'd0,
    MUX_CH0 = 2'd1,
    MUX_CH1 = 2'd2
  } mux_sel_e;

  function automatic mux_sel_e ch_mux(input logic ch);
    return ch ? MUX_CH1 : MUX_CH0;
  endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Channel picker: turns the two DMA requests into a one-hot choice.
// ARB_RR_EN defined: round-robin against last-served; otherwise ch0 wins.
module arb_pick
  import bus_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic              last_i,
  output logic [NUM_CH-1:0] pick_o
);

`ifdef ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  always_comb begin
    pick_o = '0;
    if (RR_EN && (req_i == 2'b11)) begin
      // Both asking: the channel served last yields.
      pick_o = last_i ? 2'b01 : 2'b10;
    end else if (req_i[0]) begin
      pick_o = 2'b01;
    end else if (req_i[1]) begin
      pick_o = 2'b10;
    end
  end

endmodule

// File: rtl/bus_arb.sv
// Shares one memory bus between the core and two DMA channels via CPU/GNT/REL states.
// Build with ARB_RR_EN for round-robin channel priority (fixed ch0-first otherwise).
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_AB,
  input  logic        cpu_WE,
  input  logic [7:0]  cpu_DO,
  output logic        rdy,
  input  logic [1:0]  dma_req,
  input  logic [1:0]  dma_done,
  input  logic [31:0] dma_AB,
  input  logic [1:0]  dma_WE,
  input  logic [15:0] dma_DO,
  output logic [1:0]  dma_gnt,
  output logic [15:0] mem_AB,
  output logic        mem_WE,
  output logic [7:0]  mem_DO
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pick;
  mux_sel_e      mux_sel;

  logic [15:0] ch_ab [NUM_CH];
  logic        ch_we [NUM_CH];
  logic [7:0]  ch_do [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_ab[gi] = dma_AB[gi*16 +: 16];
      // A channel that drops its request while granted must not write.
      assign ch_we[gi] = dma_WE[gi] & dma_req[gi];
      assign ch_do[gi] = dma_DO[gi*8 +: 8];
      assign dma_gnt[gi] = (state_q == ST_GNT) && (sel_q == 1'(gi));
    end
  endgenerate

  arb_pick u_pick (
    .req_i  (dma_req),
    .last_i (last_q),
    .pick_o (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CPU;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CPU: begin
        if ((|dma_req) && !cpu_WE) begin
          state_d = ST_GNT;
          sel_d   = pick[1];
          last_d  = pick[1];
          cnt_d   = '0;
        end
      end
      ST_GNT: begin
        // cnt_q counts accesses already done, so CNT_LAST marks the final one.
        if (dma_done[sel_q] || (cnt_q == CNT_LAST) || !dma_req[sel_q]) begin
          state_d = ST_REL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_REL:  state_d = ST_CPU;
      default: state_d = ST_CPU;
    endcase
  end

  assign rdy     = (state_q == ST_CPU);
  assign mux_sel = (state_q == ST_GNT) ? ch_mux(sel_q) : MUX_CPU;

  always_comb begin
    mem_AB = cpu_AB;
    mem_WE = cpu_WE;
    mem_DO = cpu_DO;
    case (mux_sel)
      MUX_CH0: begin
        mem_AB = ch_ab[0];
        mem_WE = ch_we[0];
        mem_DO = ch_do[0];
      end
      MUX_CH1: begin
        mem_AB = ch_ab[1];
        mem_WE = ch_we[1];
        mem_DO = ch_do[1];
      end
      default: ;
    endcase
  end

endmodule
